lc3_imem_responder: RTL and testbench

//  Instruction-memory responder for the LC3 fetch stage: the memory-side end of the

---
 rtl/lc3_imem_responder.sv | 118 +++++++++++
 tb/tb_lc3_imem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_imem_responder.sv
// LC3 instruction-memory responder: serves fetch reads after a fixed
// number of wait states, with branch abort and a write-only load port.
//
// Ports:
//   clock        single clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   instrmem_rd  fetch read strobe
//   pc           fetch address (low ADDR_W bits used)
//   br_taken     branch redirect, aborts a read still waiting
//   ld_en        load-port write enable
//   ld_addr      load-port word address
//   ld_data      load-port write data
//   dout         instruction word, meaningful while imem_valid=1
//   imem_valid   one-cycle response pulse
//   imem_busy    high while a read is waiting
module lc3_imem_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] RESET_INSTR = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instrmem_rd,
    input  logic [15:0]       pc,
    input  logic              br_taken,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic [15:0]       dout,
    output logic              imem_valid,
    output logic              imem_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [15:0]       mem [DEPTH];
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_a;
    logic              unused_pc;

    // Upper pc bits alias; they are deliberately dropped.
    assign pc_a      = pc[ADDR_W-1:0];
    assign unused_pc = ^pc[15:ADDR_W];

    // Array is never cleared. Reads below use the pre-edge contents,
    // so a same-edge write to the read address returns the old word.
    always_ff @(posedge clock) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            dout       <= RESET_INSTR;
            imem_valid <= 1'b0;
            imem_busy  <= 1'b0;
        end else begin
            imem_valid <= 1'b0;
            unique case (state)
                // RESP is a one-cycle state that accepts like IDLE,
                // so back-to-back requests see no extra bubble.
                IDLE, RESP: begin
                    if (instrmem_rd) begin
                        addr_q <= pc_a;
                        if (WS == 4'd0) begin
                            state      <= RESP;
                            dout       <= mem[pc_a];
                            imem_valid <= 1'b1;
                            imem_busy  <= 1'b0;
                        end else begin
                            state     <= WAIT;
                            cnt       <= WS;
                            imem_busy <= 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        imem_busy <= 1'b0;
                    end
                end
                // Request inputs are ignored here; the abort wins over
                // a response due on the same edge.
                WAIT: begin
                    if (br_taken) begin
                        state     <= IDLE;
                        cnt       <= 4'd0;
                        imem_busy <= 1'b0;
                    end else if (cnt == 4'd1) begin
                        state      <= RESP;
                        cnt        <= 4'd0;
                        dout       <= mem[addr_q];
                        imem_valid <= 1'b1;
                        imem_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_imem_responder.sv
// Bench for lc3_imem_responder: three instances (0, 2, 5 wait states)
// against a transaction-level model, plus literal directed checks.
module tb_lc3_imem_responder;

    localparam int          WS_T [3] = '{0, 2, 5};
    localparam logic [15:0] RI_T [3] = '{16'h0F0F, 16'h0000, 16'hA5A5};

    logic        clock;
    logic        rst_n;
    logic        rd;
    logic [15:0] pc;
    logic        br;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] dout_w [3];
    logic        vld_w  [3];
    logic        bsy_w  [3];

    int vectors;
    int miscompares;
    bit cmp_en;

    lc3_imem_responder #(
        .ADDR_W(8), .WAIT_STATES(0), .RESET_INSTR(16'h0F0F)
    ) u0 (
        .clock(clock), .reset(rst_n), .instrmem_rd(rd), .pc(pc),
        .br_taken(br), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dout(dout_w[0]), .imem_valid(vld_w[0]),
        .imem_busy(bsy_w[0])
    );

    lc3_imem_responder #(
        .ADDR_W(8), .WAIT_STATES(2), .RESET_INSTR(16'h0000)
    ) u1 (
        .clock(clock), .reset(rst_n), .instrmem_rd(rd), .pc(pc),
        .br_taken(br), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dout(dout_w[1]), .imem_valid(vld_w[1]),
        .imem_busy(bsy_w[1])
    );

    lc3_imem_responder #(
        .ADDR_W(8), .WAIT_STATES(5), .RESET_INSTR(16'hA5A5)
    ) u2 (
        .clock(clock), .reset(rst_n), .instrmem_rd(rd), .pc(pc),
        .br_taken(br), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dout(dout_w[2]), .imem_valid(vld_w[2]),
        .imem_busy(bsy_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a request is a pending transaction with an
    // absolute due edge number; it completes then unless aborted.
    logic [15:0] mmem   [256];
    bit          pend   [3];
    int          due    [3];
    logic [7:0]  paddr  [3];
    logic [15:0] e_dout [3];
    logic        e_vld  [3];
    logic        e_bsy  [3];
    int          edge_n = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                pend[k]   = 1'b0;
                e_vld[k]  = 1'b0;
                e_bsy[k]  = 1'b0;
                e_dout[k] = RI_T[k];
            end
        end else begin
            edge_n++;
            for (int k = 0; k < 3; k++) begin
                e_vld[k] = 1'b0;
                if (pend[k]) begin
                    if (br) begin
                        pend[k] = 1'b0;
                    end else if (edge_n == due[k]) begin
                        pend[k]   = 1'b0;
                        e_vld[k]  = 1'b1;
                        e_dout[k] = mmem[paddr[k]];
                    end
                end else if (rd) begin
                    if (WS_T[k] == 0) begin
                        e_vld[k]  = 1'b1;
                        e_dout[k] = mmem[pc[7:0]];
                    end else begin
                        pend[k]  = 1'b1;
                        due[k]   = edge_n + WS_T[k];
                        paddr[k] = pc[7:0];
                    end
                end
                e_bsy[k] = pend[k];
            end
            if (ld_en) mmem[ld_addr] = ld_data;
        end
    end

    task automatic check(input string nm, input int k,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[u%0d] t=%0t got %h want %h",
                     nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                check("valid", k, 16'(vld_w[k]), 16'(e_vld[k]));
                check("busy", k, 16'(bsy_w[k]), 16'(e_bsy[k]));
                check("dout", k, dout_w[k], e_dout[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle(input int n);
        rd    = 1'b0;
        br    = 1'b0;
        ld_en = 1'b0;
        repeat (n) tick();
    endtask

    logic [15:0] wd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmp_en      = 1'b0;
        rst_n   = 1'b1;
        rd      = 1'b0;
        pc      = 16'h0;
        br      = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 8'h0;
        ld_data = 16'h0;
        #3 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rst_dout", k, dout_w[k], RI_T[k]);
            check("rst_valid", k, 16'(vld_w[k]), 16'h0);
        end
        repeat (2) tick();
        rst_n = 1'b1;

        // Preload the whole array, with a few known words.
        for (int a = 0; a < 256; a++) begin
            case (a)
                8'h00:   wd = 16'h1111;
                8'h01:   wd = 16'h2222;
                8'h02:   wd = 16'h3333;
                8'h05:   wd = 16'h0505;
                8'h10:   wd = 16'h1234;
                8'h40:   wd = 16'h4040;
                default: wd = 16'($urandom);
            endcase
            ld_en   = 1'b1;
            ld_addr = 8'(a);
            ld_data = wd;
            tick();
        end
        settle(2);

        // Basic latency with upper pc bits set.
        rd = 1'b1;
        pc = 16'h3010;
        tick();
        rd = 1'b0;
        @(negedge clock);
        check("t1_w0_valid", 0, 16'(vld_w[0]), 16'h1);
        check("t1_w0_dout", 0, dout_w[0], 16'h1234);
        check("t1_busy_a", 1, 16'(bsy_w[1]), 16'h1);
        @(negedge clock);
        check("t1_busy_b", 1, 16'(bsy_w[1]), 16'h1);
        check("t1_novalid", 1, 16'(vld_w[1]), 16'h0);
        @(negedge clock);
        check("t1_valid", 1, 16'(vld_w[1]), 16'h1);
        check("t1_dout", 1, dout_w[1], 16'h1234);
        check("t1_busy_off", 1, 16'(bsy_w[1]), 16'h0);
        settle(8);

        // Back-to-back at zero wait states.
        rd = 1'b1;
        pc = 16'h0000;
        tick();
        pc = 16'h0001;
        @(negedge clock);
        check("t2_d0", 0, dout_w[0], 16'h1111);
        tick();
        pc = 16'h0002;
        @(negedge clock);
        check("t2_d1", 0, dout_w[0], 16'h2222);
        tick();
        rd = 1'b0;
        @(negedge clock);
        check("t2_d2", 0, dout_w[0], 16'h3333);
        check("t2_v2", 0, 16'(vld_w[0]), 16'h1);
        settle(8);

        // Abort on the first waiting edge, then a fresh request.
        rd = 1'b1;
        pc = 16'h0020;
        tick();
        rd = 1'b0;
        br = 1'b1;
        tick();
        br = 1'b0;
        @(negedge clock);
        check("t3_busy", 1, 16'(bsy_w[1]), 16'h0);
        check("t3_valid", 1, 16'(vld_w[1]), 16'h0);
        settle(3);
        rd = 1'b1;
        pc = 16'h0040;
        tick();
        rd = 1'b0;
        repeat (3) @(negedge clock);
        check("t3_valid2", 1, 16'(vld_w[1]), 16'h1);
        check("t3_dout2", 1, dout_w[1], 16'h4040);
        settle(8);

        // Asynchronous reset while waiting.
        rd = 1'b1;
        pc = 16'h0033;
        tick();
        rd = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t4_dout", k, dout_w[k], RI_T[k]);
            check("t4_busy", k, 16'(bsy_w[k]), 16'h0);
            check("t4_valid", k, 16'(vld_w[k]), 16'h0);
        end
        tick();
        @(posedge clock);
        #4 rst_n = 1'b1;
        settle(9);

        // Write on the edge that captures the read word.
        rd = 1'b1;
        pc = 16'h0005;
        tick();
        rd = 1'b0;
        tick();
        ld_en   = 1'b1;
        ld_addr = 8'h05;
        ld_data = 16'hBEEF;
        tick();
        ld_en = 1'b0;
        @(negedge clock);
        check("t5_valid", 1, 16'(vld_w[1]), 16'h1);
        check("t5_old", 1, dout_w[1], 16'h0505);
        settle(8);
        rd = 1'b1;
        pc = 16'h0005;
        tick();
        rd = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_new", 1, dout_w[1], 16'hBEEF);
        settle(8);

        // Address aliasing.
        rd = 1'b1;
        pc = 16'hFF05;
        tick();
        rd = 1'b0;
        @(negedge clock);
        check("t6_valid", 0, 16'(vld_w[0]), 16'h1);
        check("t6_alias", 0, dout_w[0], 16'hBEEF);
        settle(8);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rd = 1'($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                pc = 16'($urandom);
            else
                pc = {8'($urandom), 8'($urandom_range(0, 15))};
            br      = 1'($urandom_range(0, 7) == 0);
            ld_en   = 1'($urandom_range(0, 3) == 0);
            ld_addr = 8'($urandom_range(0, 15));
            ld_data = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                ld_en = 1'b0;
                rst_n = 1'b0;
                tick();
                @(posedge clock);
                #3 rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        settle(10);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
